multicycle_control_unit: RTL and testbench

- Control-side counterpart of the RV32I datapath.
- Consumes the decoded fields `opcode`, `lorbtype`, `alu_action` and the ALU flag `zero`.
- Sequences each instruction through a multi-cycle FSM and drives every datapath control input: PC select/enable, ALU source/op, immediate format, memory strobes, write-back select, register write enable.
- Also performs the boot-time PC load from `initialize`.

---
 rtl/ctrl_pkg.sv | 84 ++++++++
 rtl/ctrl_alu_decode.sv | 63 ++++++
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
// Holds the FSM state set, opcode map, mux select codes and the write-back helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST, S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
    } class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;
    localparam logic [1:0] PC_INIT  = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PCIMM = 2'b10;
    localparam logic [1:0] WB_PC4   = 2'b11;

    localparam logic [4:0] OPR_ADD     = 5'b00000;
    localparam logic [4:0] OPR_SUB     = 5'b01000;
    localparam logic [4:0] OPR_PASSB   = 5'b11111;
    localparam logic [4:0] OPR_BR_BASE = 5'b10000;

    typedef struct packed {
        class_t     cls;
        logic       alu_src;
        logic [4:0] opr;
        logic [2:0] immsrc;
    } dec_t;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic [1:0] mem_to_reg;
        logic       en_w;
    } wb_ctrl_t;

    // Write-back controls for a class; taken is the branch outcome from EXEC.
    function automatic wb_ctrl_t wb_ctrl(class_t cls, logic taken);
        wb_ctrl_t w;
        w = '{pc_sel: PC_PLUS4, mem_to_reg: WB_ALU, en_w: 1'b1};
        case (cls)
            CL_LOAD:    w.mem_to_reg = WB_MEM;
            CL_STORE:   w.en_w = 1'b0;
            CL_BRANCH: begin
                w.en_w   = 1'b0;
                w.pc_sel = taken ? PC_IMM : PC_PLUS4;
            end
            CL_JAL: begin
                w.pc_sel     = PC_IMM;
                w.mem_to_reg = WB_PC4;
            end
            CL_JALR: begin
                w.pc_sel     = PC_ALU;
                w.mem_to_reg = WB_PC4;
            end
            CL_AUIPC:   w.mem_to_reg = WB_PCIMM;
            CL_ILLEGAL: w.en_w = 1'b0;
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// Combinational opcode classifier: selects ALU operation, ALU operand source
// and immediate format for the instruction currently held by the decoder.
module ctrl_alu_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [3:0] alu_action,
    input  logic [2:0] lorbtype,
    output dec_t       dec
);

    always_comb begin
        dec = '{cls: CL_ILLEGAL, alu_src: 1'b0, opr: OPR_ADD, immsrc: IMM_I};
        case (opcode)
            OP_R: begin
                dec.cls = CL_R;
                dec.opr = {1'b0, alu_action};
            end
            OP_I: begin
                dec.cls     = CL_I;
                dec.alu_src = 1'b1;
                // only the shift-right pair uses funct7[5] to pick SRAI vs SRLI
                dec.opr     = (alu_action[2:0] == 3'b101) ? {1'b0, alu_action}
                                                          : {2'b00, alu_action[2:0]};
            end
            OP_LOAD: begin
                dec.cls     = CL_LOAD;
                dec.alu_src = 1'b1;
            end
            OP_STORE: begin
                dec.cls     = CL_STORE;
                dec.alu_src = 1'b1;
                dec.immsrc  = IMM_S;
            end
            OP_BRANCH: begin
                dec.cls    = CL_BRANCH;
                dec.opr    = OPR_BR_BASE | {2'b00, lorbtype};
                dec.immsrc = IMM_B;
            end
            OP_JAL: begin
                dec.cls    = CL_JAL;
                dec.immsrc = IMM_J;
            end
            OP_JALR: begin
                dec.cls     = CL_JALR;
                dec.alu_src = 1'b1;
            end
            OP_LUI: begin
                dec.cls     = CL_LUI;
                dec.alu_src = 1'b1;
                dec.opr     = OPR_PASSB;
                dec.immsrc  = IMM_U;
            end
            OP_AUIPC: begin
                dec.cls     = CL_AUIPC;
                dec.alu_src = 1'b1;
                dec.immsrc  = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer driving the RV32I datapath controls.
// Optional performance counters are compiled in with CTRL_PERF_EN.
//
// state  | meaning
// RST    | held in reset, all outputs 0
// INIT   | PC loads the boot address
// FETCH  | decoder registers the instruction
// DECODE | immediate format driven, opcode classified
// EXEC   | ALU runs, branch flag captured
// MEM    | data memory access plus MEM_WAIT stall cycles
// WB     | PC update and register write
// TRAP   | illegal opcode seen, halted until reset
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT        = 0,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  lorbtype,
    input  logic [3:0]  alu_action,
    input  logic        zero,
    output logic        PCsel1,
    output logic        PCsel0,
    output logic        enPC,
    output logic        ALUsrc,
    output logic [2:0]  immsrc,
    output logic        memtoreg1,
    output logic        memtoreg0,
    output logic        read_mem,
    output logic        write_mem,
    output logic        enW,
    output logic [4:0]  opr,
    output logic        illegal
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    state_t     state;
    class_t     cls_q;
    dec_t       dec;
    logic [3:0] wait_cnt;
    logic [2:0] immsrc_q;
    logic [1:0] pc_sel;
    logic [1:0] mem_to_reg;

    ctrl_alu_decode u_dec (
        .opcode     (opcode),
        .alu_action (alu_action),
        .lorbtype   (lorbtype),
        .dec        (dec)
    );

    assign {PCsel1, PCsel0}       = pc_sel;
    assign {memtoreg1, memtoreg0} = mem_to_reg;

    // The immediate generator samples during DECODE, so the format bypasses the register there.
    assign immsrc = (state == S_DECODE) ? dec.immsrc :
                    (state inside {S_EXEC, S_MEM, S_WB}) ? immsrc_q : IMM_I;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_RST;
            cls_q      <= CL_R;
            wait_cnt   <= '0;
            immsrc_q   <= IMM_I;
            pc_sel     <= PC_PLUS4;
            mem_to_reg <= WB_ALU;
            enPC       <= 1'b0;
            ALUsrc     <= 1'b0;
            read_mem   <= 1'b0;
            write_mem  <= 1'b0;
            enW        <= 1'b0;
            opr        <= OPR_ADD;
            illegal    <= 1'b0;
        end else begin
            pc_sel     <= PC_PLUS4;
            mem_to_reg <= WB_ALU;
            enPC       <= 1'b0;
            read_mem   <= 1'b0;
            write_mem  <= 1'b0;
            enW        <= 1'b0;
            case (state)
                S_RST: begin
                    state  <= S_INIT;
                    pc_sel <= PC_INIT;
                    enPC   <= 1'b1;
                end
                S_INIT: begin
                    state  <= S_FETCH;
                    ALUsrc <= 1'b0;
                    opr    <= OPR_ADD;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    cls_q    <= dec.cls;
                    immsrc_q <= dec.immsrc;
                    ALUsrc   <= dec.alu_src;
                    opr      <= dec.opr;
                    if (dec.cls != CL_ILLEGAL) begin
                        state <= S_EXEC;
                    end else if (TRAP_ON_ILLEGAL) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state <= S_WB;
                        enPC  <= 1'b1;
                        {pc_sel, mem_to_reg, enW} <= wb_ctrl(CL_ILLEGAL, 1'b0);
                    end
                end
                S_EXEC: begin
                    if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
                        state     <= S_MEM;
                        wait_cnt  <= 4'(MEM_WAIT);
                        read_mem  <= (cls_q == CL_LOAD);
                        write_mem <= (cls_q == CL_STORE) && (MEM_WAIT == 0);
                    end else begin
                        state <= S_WB;
                        enPC  <= 1'b1;
                        // zero is the branch outcome sampled at the end of EXEC
                        {pc_sel, mem_to_reg, enW} <= wb_ctrl(cls_q, zero);
                    end
                end
                S_MEM: begin
                    read_mem <= (cls_q == CL_LOAD);
                    if (wait_cnt == 4'd0) begin
                        state <= S_WB;
                        enPC  <= 1'b1;
                        {pc_sel, mem_to_reg, enW} <= wb_ctrl(cls_q, 1'b0);
                    end else begin
                        wait_cnt  <= wait_cnt - 4'd1;
                        write_mem <= (cls_q == CL_STORE) && (wait_cnt == 4'd1);
                    end
                end
                S_WB: begin
                    state  <= S_FETCH;
                    ALUsrc <= 1'b0;
                    opr    <= OPR_ADD;
                end
                S_TRAP: state <= S_TRAP;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state != S_RST && state != S_TRAP)
                cycle_count <= cycle_count + 32'd1;
            if (state == S_WB)
                instret_count <= instret_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MEM_WAIT = 2, trap on illegal).
// A per-instruction cycle schedule model predicts every output on every cycle.
module tb_multicycle_control_unit;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] lorbtype = 3'd0;
    logic [3:0] alu_action = 4'd0;
    logic       zero = 1'b0;
    logic       PCsel1, PCsel0, enPC, ALUsrc, memtoreg1, memtoreg0;
    logic       read_mem, write_mem, enW, illegal;
    logic [2:0] immsrc;
    logic [4:0] opr;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_count, instret_count;
`endif

    multicycle_control_unit #(.MEM_WAIT(W), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .lorbtype(lorbtype),
        .alu_action(alu_action), .zero(zero),
        .PCsel1(PCsel1), .PCsel0(PCsel0), .enPC(enPC), .ALUsrc(ALUsrc),
        .immsrc(immsrc), .memtoreg1(memtoreg1), .memtoreg0(memtoreg0),
        .read_mem(read_mem), .write_mem(write_mem), .enW(enW),
        .opr(opr), .illegal(illegal)
`ifdef CTRL_PERF_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int checks = 0, failures = 0;
    int rd_cnt = 0, wr_cnt = 0, enw_cnt = 0, lim = 0;
    logic [17:0] act, wb_snap;
    assign act = {PCsel1, PCsel0, enPC, ALUsrc, immsrc, memtoreg1, memtoreg0,
                  read_mem, write_mem, enW, opr, illegal};

    typedef struct { int cyc; logic [17:0] v; string name; } exp_t;
    exp_t q[$];

    typedef struct {
        logic legal, asrc, ld, st, wb_en;
        logic [2:0] imm;
        logic [4:0] opr;
        logic [1:0] pcsel, m2r;
    } info_t;

    function automatic logic [17:0] mk(logic [1:0] pcs, logic enpc, logic asrc, logic [2:0] imm,
                                       logic [1:0] m2r, logic rd, logic wr, logic enw,
                                       logic [4:0] op, logic ill);
        return {pcs, enpc, asrc, imm, m2r, rd, wr, enw, op, ill};
    endfunction

    // Per-opcode behaviour taken straight from the instruction class table.
    function automatic info_t model(logic [6:0] op, logic [3:0] aa, logic [2:0] f3, logic taken);
        info_t m;
        m = '{default: 0};
        m.legal = 1'b1;
        m.wb_en = 1'b1;
        case (op)
            7'b0110011: m.opr = {1'b0, aa};
            7'b0010011: begin m.asrc = 1; m.opr = (f3 == 3'b101) ? {1'b0, aa} : {2'b00, f3}; end
            7'b0000011: begin m.asrc = 1; m.ld = 1; m.m2r = 2'b01; end
            7'b0100011: begin m.asrc = 1; m.st = 1; m.imm = 3'b001; m.wb_en = 0; end
            7'b1100011: begin m.imm = 3'b010; m.opr = {2'b10, f3}; m.wb_en = 0;
                              m.pcsel = taken ? 2'b01 : 2'b00; end
            7'b1101111: begin m.imm = 3'b100; m.pcsel = 2'b01; m.m2r = 2'b11; end
            7'b1100111: begin m.asrc = 1; m.pcsel = 2'b10; m.m2r = 2'b11; end
            7'b0110111: begin m.asrc = 1; m.imm = 3'b011; m.opr = 5'b11111; end
            7'b0010111: begin m.asrc = 1; m.imm = 3'b011; m.m2r = 2'b10; end
            default:    begin m.legal = 0; m.wb_en = 0; end
        endcase
        return m;
    endfunction

    task automatic push(int c, logic [17:0] v, string n);
        if (lim == 0 || c < lim) q.push_back('{cyc: c, v: v, name: n});
    endtask

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cnt) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cnt || act !== e.v) begin
                failures++;
                $display("FAIL %s cyc=%0d: got %h want %h", e.name, e.cyc, act, e.v);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            rd_cnt  += int'(read_mem);
            wr_cnt  += int'(write_mem);
            enw_cnt += int'(enW);
            if (enPC) wb_snap = act;
        end
    end

    // Called right after a rising edge; returns right after the edge that starts the next FETCH.
    task automatic run_instr(string nm, logic [6:0] op, logic [3:0] aa, logic [2:0] f3,
                             logic ze, logic zw, int cut);
        int f, wb, end_c;
        info_t m;
        f = cnt;
        m = model(op, aa, f3, ze);
        opcode = op; alu_action = aa; lorbtype = f3; zero = zw;
        lim = (cut > 0) ? f + cut : 0;
        push(f, 18'd0, {nm, ":fetch"});
        push(f + 1, mk(2'b00, 0, 0, m.imm, 2'b00, 0, 0, 0, 5'd0, 0), {nm, ":decode"});
        push(f + 2, mk(2'b00, 0, m.asrc, m.imm, 2'b00, 0, 0, 0, m.opr, 0), {nm, ":exec"});
        if (m.ld || m.st) begin
            for (int k = 0; k <= W; k++)
                push(f + 3 + k, mk(2'b00, 0, m.asrc, m.imm, 2'b00, m.ld, m.st && (k == W), 0, m.opr, 0),
                     {nm, ":mem"});
            wb = f + 4 + W;
        end else begin
            wb = f + 3;
        end
        push(wb, mk(m.pcsel, 1, m.asrc, m.imm, m.m2r, m.ld, 0, m.wb_en, m.opr, 0), {nm, ":wb"});
        lim = 0;
        end_c = (cut > 0) ? f + cut - 1 : wb + 1;
        @(posedge clk); #1;
        @(posedge clk); #1; zero = ze;
        @(posedge clk); #1; zero = zw;
        while (cnt < end_c) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(string nm);
        @(posedge clk); #3;
        q.delete();
        reset = 1'b0;
        #1 chk({nm, "_async"}, act, 32'd0);
        repeat (2) begin @(negedge clk); chk({nm, "_held"}, act, 32'd0); end
        @(negedge clk); #1;
        reset = 1'b1;
        push(cnt + 1, mk(2'b11, 1, 0, 3'b000, 2'b00, 0, 0, 0, 5'd0, 0), {nm, ":init"});
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        do_reset("boot");
        chk("boot_illegal", {31'd0, illegal}, 32'd0);

        run_instr("add", 7'b0110011, 4'b0000, 3'b000, 0, 0, 0);
        chk("add_wb", wb_snap, mk(2'b00, 1, 0, 3'b000, 2'b00, 0, 0, 1, 5'b00000, 0));
        run_instr("sub", 7'b0110011, 4'b1000, 3'b000, 0, 0, 0);
        run_instr("srai", 7'b0010011, 4'b1101, 3'b101, 0, 0, 0);
        chk("srai_wb", wb_snap, mk(2'b00, 1, 1, 3'b000, 2'b00, 0, 0, 1, 5'b01101, 0));
        run_instr("addi_f7", 7'b0010011, 4'b1000, 3'b000, 0, 0, 0);
        chk("addi_f7_wb", wb_snap, mk(2'b00, 1, 1, 3'b000, 2'b00, 0, 0, 1, 5'b00000, 0));

        rd_cnt = 0; wr_cnt = 0; enw_cnt = 0;
        run_instr("lw", 7'b0000011, 4'b0010, 3'b010, 0, 0, 0);
        chk("lw_read_cycles", rd_cnt, 4);
        chk("lw_enw_pulses", enw_cnt, 1);
        chk("lw_wb", wb_snap, mk(2'b00, 1, 1, 3'b000, 2'b01, 1, 0, 1, 5'b00000, 0));

        rd_cnt = 0; wr_cnt = 0; enw_cnt = 0;
        run_instr("sw", 7'b0100011, 4'b0010, 3'b010, 0, 0, 0);
        chk("sw_write_pulses", wr_cnt, 1);
        chk("sw_enw", enw_cnt, 0);

        run_instr("beq_t", 7'b1100011, 4'b0000, 3'b000, 1, 0, 0);
        chk("beq_t_wb", wb_snap, mk(2'b01, 1, 0, 3'b010, 2'b00, 0, 0, 0, 5'b10000, 0));
        run_instr("beq_nt", 7'b1100011, 4'b0000, 3'b000, 0, 1, 0);
        chk("beq_nt_wb", wb_snap, mk(2'b00, 1, 0, 3'b010, 2'b00, 0, 0, 0, 5'b10000, 0));
        run_instr("bne_t", 7'b1100011, 4'b0001, 3'b001, 1, 1, 0);
        run_instr("jal", 7'b1101111, 4'b0000, 3'b000, 0, 0, 0);
        run_instr("jalr", 7'b1100111, 4'b0000, 3'b000, 0, 0, 0);
        run_instr("lui", 7'b0110111, 4'b0000, 3'b000, 0, 0, 0);
        chk("lui_wb", wb_snap, mk(2'b00, 1, 1, 3'b011, 2'b00, 0, 0, 1, 5'b11111, 0));
        run_instr("auipc", 7'b0010111, 4'b0000, 3'b000, 0, 0, 0);

        wr_cnt = 0;
        run_instr("sw_abort", 7'b0100011, 4'b0010, 3'b010, 0, 0, 4);
        do_reset("midmem");
        chk("midmem_no_write", wr_cnt, 0);

        enw_cnt = 0;
        begin
            int f;
            f = cnt;
            opcode = 7'b1111111; alu_action = 4'b0000; lorbtype = 3'b000;
            push(f, 18'd0, "trap:fetch");
            push(f + 1, 18'd0, "trap:decode");
            for (int k = 2; k < 10; k++)
                push(f + k, mk(2'b00, 0, 0, 3'b000, 2'b00, 0, 0, 0, 5'd0, 1), "trap:hold");
            while (cnt < f + 10) begin @(posedge clk); #1; end
        end
        chk("trap_illegal", {31'd0, illegal}, 32'd1);
        chk("trap_enw", enw_cnt, 0);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
